// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter that sequences one shared ripple add/subtract unit.
// Optional ADDSUB_ARB_STATS_EN adds saturating completed-op and overflow counters.
module addsub_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic             req1_sub,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_cout,
    output logic             rsp0_ovf,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_cout,
`ifdef ADDSUB_ARB_STATS_EN
    output logic [7:0]       stat_ops,
    output logic [7:0]       stat_ovf,
`endif
    output logic             rsp1_ovf
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    // Ripple adder; subtraction feeds ~y with carry-in 1. Returns {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] add_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic sub);
        logic [WIDTH-1:0] s;
        logic             c;
        logic             c_msb;
        logic             yb;
        c     = sub;
        c_msb = 1'b0;
        s     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            yb    = y[i] ^ sub;
            c_msb = c;
            s[i]  = x[i] ^ yb ^ c;
            c     = (x[i] & yb) | (c & (x[i] ^ yb));
        end
        return {c_msb ^ c, c, s};
    endfunction

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             sub_q, sub_d;
    logic             v0_q, v0_d, v1_q, v1_d;
    logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
    logic             c0_q, c0_d, c1_q, c1_d;
    logic             o0_q, o0_d, o1_q, o1_d;
    logic             grant_s;
    logic [WIDTH+1:0] res_s;

    // Next-state, grant selection and handshake decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        x_d          = x_q;
        y_d          = y_q;
        sub_d        = sub_q;
        v0_d = v0_q; s0_d = s0_q; c0_d = c0_q; o0_d = o0_q;
        v1_d = v1_q; s1_d = s1_q; c1_d = c1_q; o1_d = o1_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        res_s        = add_sub(x_q, y_q, sub_q);
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if ((req0_valid || req1_valid) && !rst) begin
                    req0_ready = ~grant_s;
                    req1_ready = grant_s;
                    gnt_d      = grant_s;
                    x_d        = grant_s ? req1_x : req0_x;
                    y_d        = grant_s ? req1_y : req0_y;
                    sub_d      = grant_s ? req1_sub : req0_sub;
                    state_d    = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (gnt_q) begin
                    v1_d = 1'b1; s1_d = res_s[WIDTH-1:0]; c1_d = res_s[WIDTH]; o1_d = res_s[WIDTH+1];
                end else begin
                    v0_d = 1'b1; s0_d = res_s[WIDTH-1:0]; c0_d = res_s[WIDTH]; o0_d = res_s[WIDTH+1];
                end
                state_d = RESP;
            end
            RESP: begin
                if (gnt_q && v1_q && rsp1_ready) begin
                    v1_d         = 1'b0;
                    last_grant_d = 1'b1;
                    state_d      = IDLE;
                end else if (!gnt_q && v0_q && rsp0_ready) begin
                    v0_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, operand and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            sub_q        <= 1'b0;
            v0_q <= 1'b0; s0_q <= '0; c0_q <= 1'b0; o0_q <= 1'b0;
            v1_q <= 1'b0; s1_q <= '0; c1_q <= 1'b0; o1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sub_q        <= sub_d;
            v0_q <= v0_d; s0_q <= s0_d; c0_q <= c0_d; o0_q <= o0_d;
            v1_q <= v1_d; s1_q <= s1_d; c1_q <= c1_d; o1_q <= o1_d;
        end
    end

    assign rsp0_valid = v0_q;
    assign rsp0_sum   = s0_q;
    assign rsp0_cout  = c0_q;
    assign rsp0_ovf   = o0_q;
    assign rsp1_valid = v1_q;
    assign rsp1_sum   = s1_q;
    assign rsp1_cout  = c1_q;
    assign rsp1_ovf   = o1_q;

`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] stat_ops_q, stat_ops_d, stat_ovf_q, stat_ovf_d;
    logic       consume_s, consume_ovf_s;

    // Saturating counters bumped on each response-consume edge.
    always_comb begin
        consume_s     = (state_q == RESP) &&
                        (gnt_q ? (v1_q && rsp1_ready) : (v0_q && rsp0_ready));
        consume_ovf_s = consume_s && (gnt_q ? o1_q : o0_q);
        stat_ops_d    = stat_ops_q;
        stat_ovf_d    = stat_ovf_q;
        if (consume_s && (stat_ops_q != 8'd255)) begin
            stat_ops_d = stat_ops_q + 8'd1;
        end else begin
            stat_ops_d = stat_ops_q;
        end
        if (consume_ovf_s && (stat_ovf_q != 8'd255)) begin
            stat_ovf_d = stat_ovf_q + 8'd1;
        end else begin
            stat_ovf_d = stat_ovf_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q <= 8'd0;
            stat_ovf_q <= 8'd0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_ovf_q <= stat_ovf_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed scoreboard bench for addsub_arbiter (WIDTH=5); stats checks only when ADDSUB_ARB_STATS_EN is defined.
module tb_addsub_arbiter;

    localparam int W = 5;

    typedef struct {
        int         id;
        logic [4:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic req0_sub = 1'b0, req1_sub = 1'b0;
    logic rsp0_valid, rsp1_valid;
    logic rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [W-1:0] rsp0_sum, rsp1_sum;
    logic rsp0_cout, rsp0_ovf, rsp1_cout, rsp1_ovf;
`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] stat_ops, stat_ovf;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
`ifdef ADDSUB_ARB_STATS_EN
        .stat_ops(stat_ops), .stat_ovf(stat_ovf),
`endif
        .rsp1_ovf(rsp1_ovf)
    );

    always #5 clk = ~clk;

    // Reference arithmetic via signed/unsigned integer math.
    function automatic exp_t model(input int id, input int x, input int y, input bit sub);
        exp_t e;
        int   sx, sy, r, u;
        sx = (x >= 16) ? x - 32 : x;
        sy = (y >= 16) ? y - 32 : y;
        r  = sub ? sx - sy : sx + sy;
        u  = sub ? x + 32 - y : x + y;
        e.id   = id;
        e.sum  = u[4:0];
        e.cout = (u >= 32);
        e.ovf  = (r > 15) || (r < -16);
        return e;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((n == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) check("ready_timeout", 8'd0, 8'd1);
    endtask

    // Pop the oldest expectation and compare against the channel it names.
    task automatic check_rsp(input int n);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 8'd1, 8'd0);
            return;
        end
        e = sb.pop_front();
        check("rsp_id", 8'(n), 8'(e.id));
        if (n == 0) begin
            check("rsp0_valid", rsp0_valid, 1'b1);
            check("rsp0_sum", rsp0_sum, e.sum);
            check("rsp0_cout", rsp0_cout, e.cout);
            check("rsp0_ovf", rsp0_ovf, e.ovf);
            check("rsp1_idle", rsp1_valid, 1'b0);
        end else begin
            check("rsp1_valid", rsp1_valid, 1'b1);
            check("rsp1_sum", rsp1_sum, e.sum);
            check("rsp1_cout", rsp1_cout, e.cout);
            check("rsp1_ovf", rsp1_ovf, e.ovf);
            check("rsp0_idle", rsp0_valid, 1'b0);
        end
    endtask

    // Single operation from requester n, response consumed immediately.
    task automatic run_op(input int n, input int x, input int y, input bit sub);
        if (n == 0) begin
            req0_valid = 1'b1; req0_x = 5'(x); req0_y = 5'(y); req0_sub = sub;
        end else begin
            req1_valid = 1'b1; req1_x = 5'(x); req1_y = 5'(y); req1_sub = sub;
        end
        sb.push_back(model(n, x, y, sub));
        wait_ready(n);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("lat_not_yet", (n == 0) ? rsp0_valid : rsp1_valid, 1'b0);
        tick();
        check_rsp(n);
        tick();
        check("consumed", (n == 0) ? rsp0_valid : rsp1_valid, 1'b0);
    endtask

    initial begin
        exp_t held;
        int   g;

        // Reset: outputs clear, ready suppressed even with a pending request.
        req0_valid = 1'b1;
        tick();
        tick();
        #1;
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_rsp0_sum", rsp0_sum, 5'd0);
        check("rst_rsp1_sum", rsp1_sum, 5'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Basic arithmetic cases.
        run_op(0, 7, 5, 1'b0);
        run_op(1, 15, 1, 1'b0);
        run_op(1, 3, 5, 1'b1);
        run_op(1, 16, 1, 1'b1);
        run_op(0, 31, 31, 1'b0);
        run_op(0, 4, 0, 1'b1);

        // Fairness: both continuously valid after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_x = 5'd7; req0_y = 5'd5; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_x = 5'd3; req1_y = 5'd5; req1_sub = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            g = req1_ready ? 1 : 0;
            check("fair_grant", 8'(g), 8'(i % 2));
            check("fair_onehot", 8'(req0_ready) + 8'(req1_ready), 8'd1);
            sb.push_back((g == 0) ? model(0, 7, 5, 1'b0) : model(1, 3, 5, 1'b1));
            tick();
            check("fair_ready_pulse", 8'(req0_ready) + 8'(req1_ready), 8'd0);
            tick();
            check_rsp(g);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Backpressure on response 0 while requester 1 waits.
        req0_valid = 1'b1; req0_x = 5'd9; req0_y = 5'd9; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_x = 5'd1; req1_y = 5'd2; req1_sub = 1'b0;
        rsp0_ready = 1'b0;
        held = model(0, 9, 9, 1'b0);
        sb.push_back(held);
        #1;
        check("bp_req0_first", req0_ready, 1'b1);
        check("bp_req1_wait", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        tick();
        check_rsp(0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", rsp0_valid, 1'b1);
            check("bp_hold_sum", rsp0_sum, held.sum);
            check("bp_hold_cout", rsp0_cout, held.cout);
            check("bp_hold_ovf", rsp0_ovf, held.ovf);
            check("bp_no_ready", 8'(req0_ready) + 8'(req1_ready), 8'd0);
        end
        rsp0_ready = 1'b1;
        tick();
        check("bp_release", rsp0_valid, 1'b0);
        check("bp_req1_granted", req1_ready, 1'b1);
        sb.push_back(model(1, 1, 2, 1'b0));
        tick();
        req1_valid = 1'b0;
        tick();
        check_rsp(1);
        tick();

        // Reset during EXEC abandons the operation.
        req0_valid = 1'b1; req0_x = 5'd2; req0_y = 5'd2; req0_sub = 1'b0;
        wait_ready(0);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_rsp", rsp0_valid, 1'b0);
            tick();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_x = 5'd6; req1_y = 5'd1; req1_sub = 1'b1;
        #1;
        check("post_rst_req0_first", req0_ready, 1'b1);
        check("post_rst_req1_wait", req1_ready, 1'b0);
        sb.push_back(model(0, 2, 2, 1'b0));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check_rsp(0);
        tick();

`ifdef ADDSUB_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stat_ops_rst", stat_ops, 8'd0);
        run_op(1, 15, 1, 1'b0);
        run_op(0, 7, 5, 1'b0);
        check("stat_ops_2", stat_ops, 8'd2);
        check("stat_ovf_1", stat_ovf, 8'd1);
        for (int i = 0; i < 298; i++) begin
            run_op(i % 2, 15, 1, 1'b0);
        end
        check("stat_ops_sat", stat_ops, 8'd255);
        check("stat_ovf_sat", stat_ovf, 8'd255);
`endif

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for one shared WIDTH-bit ripple add/subtract unit.
- Sub is implemented as X + ~Y + 1; cout is the carry out of the MSB; signed overflow is carry-into-MSB XOR carry-out.
- Each requester presents operands with a valid/ready handshake and receives its registered result on a private valid/ready response channel.
- Sits between arithmetic clients (e.g. a sequencer and a host port) and the single add/sub datapath.

Parameters:
WIDTH, 5, operand/result width in bits (min 2)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_x  in  WIDTH  requester 0 operand X
req0_y  in  WIDTH  requester 0 operand Y
req0_sub  in  1  0 = X+Y, 1 = X-Y
req1_valid, req1_ready, req1_x, req1_y, req1_sub  same as requester 0, for requester 1
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 consumes result
rsp0_sum  out  WIDTH  result bits
rsp0_cout  out  1  carry out of MSB (sub: 1 = no borrow)
rsp0_ovf  out  1  signed overflow
rsp1_valid, rsp1_ready, rsp1_sum, rsp1_cout, rsp1_ovf  same as response 0, for requester 1

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all rsp*_valid=0, rsp*_sum=0, rsp*_cout=0, rsp*_ovf=0; last_grant=1, so requester 0 wins the first tie. req*_ready is 0 while rst=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Exactly one reqN_valid=1: grant N.
  - Both valid: grant the one that is not last_grant.
  - reqN_ready is combinational: 1 only in IDLE for the granted N, 0 otherwise.
  - On the accept edge, latch x, y, sub and grant id; go to EXEC.
  - No valid: stay in IDLE.
- EXEC: the datapath computes on the latched operands. At the edge, write sum/cout/ovf into the granted requester's response register, set its rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid and the result are held stable until rspN_ready=1.
  - On the edge with rspN_valid && rspN_ready: clear rspN_valid, set last_grant=N, go to IDLE.
  - The non-granted response channel stays 0 throughout.
- Latency: accept at edge k, rspN_valid=1 after edge k+1. Minimum 3 cycles per operation (IDLE, EXEC, RESP with immediate ready).
- Request-side rules:
  - A requester must hold valid and operands stable until ready.
  - The arbiter never drops or reorders an accepted operation.
  - Dropping valid before ready is legal; the operation is then not performed.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH. cout and ovf are computed over the full WIDTH bits.
  - ovf is the two's-complement signed overflow (carry into bit WIDTH-1 XOR carry out of bit WIDTH-1).
- Reset in EXEC or RESP abandons the operation: no response is delivered, and the state after the edge equals the reset state.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...

Optional Feature:
Macro ADDSUB_ARB_STATS_EN.
- Defined: adds output ports stat_ops (8 bits, count of completed responses, both requesters) and stat_ovf (8 bits, count of completed responses with ovf=1).
  - Both increment on the response-consume edge.
  - Both saturate at 255 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 7+5 (sub=0), rsp0_ready=1 -> rsp0_valid one cycle after accept; sum=01100 (12), cout=0, ovf=0; rsp1_valid stays 0.
- req1 15+1 -> sum=10000, cout=0, ovf=1. req1 3-5 -> sum=11110 (30), cout=0, ovf=0. req1 16-1 (10000-00001) -> sum=01111, cout=1, ovf=1.
- After reset, req0 and req1 valid together with constant operands for 4 operations -> grant order 0,1,0,1; each req_ready pulses exactly once per accepted operation.
- Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid -> sum/cout/ovf held stable, no new req*_ready, req1 waits; rsp0_ready=1 -> IDLE next cycle, req1 granted.
- rst asserted in the EXEC cycle of req0 2+2 -> rsp0_valid never rises; after reset release, req0 and req1 both valid -> req0 granted first.
- With ADDSUB_ARB_STATS_EN: the overflow and non-overflow cases above -> stat_ops/stat_ovf match the counts delivered; 300 operations -> stat_ops=255.
